nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 18 +
 rtl/nibble_serial_adder_rca4.sv | 25 ++
 rtl/nibble_serial_adder.sv | 142 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width,
// and a helper sizing the nibble index register.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [1:0] state_t;

  // Index register width: clog2 of the nibble count, never narrower than 1 bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca4.sv
// 4-bit ripple-carry adder: the single arithmetic slice reused every RUN cycle.
module ripple_carry_adder_4bit
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                c_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                c_o
);

  // Chain of full adders, bit 0 first.
  always_comb begin
    logic [NIBBLE_W:0] c;
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder. Operands are captured on the input handshake,
// then one 4-bit slice per cycle (LSB first) goes through a shared 4-bit adder
// with a registered carry between slices. The result is held until the output
// handshake completes.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// RUN   | adding nibble idx_q, one slice per cycle
// DONE  | sum/cout valid and stable until out_ready
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
    end
  endgenerate

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic [WIDTH-1:0]        sum_q, sum_d;
  logic                    carry_q, carry_d;
  logic                    cout_q, cout_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [NIBBLE_W-1:0]     a_nib;
  logic [NIBBLE_W-1:0]     b_nib;
  logic [NIBBLE_W-1:0]     add_sum;
  logic                    add_cout;

  // Select the operand slices addressed by idx_q. Out-of-range indices
  // (non-power-of-two nibble counts) feed zeros; they are never used.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_nib = a_q[n*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  ripple_carry_adder_4bit u_rca (
    .a_i (a_nib),
    .b_i (b_nib),
    .c_i (carry_q),
    .s_o (add_sum),
    .c_o (add_cout)
  );

  // FSM and datapath next-state: capture, slice-by-slice accumulate, hold.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == IDX_W'(n)) begin
            sum_d[n*NIBBLE_W +: NIBBLE_W] = add_sum;
          end
        end
        carry_d = add_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any operation in flight and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  // Handshake flags come from state only; in_ready is also held low during reset.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=4 instances).
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;

  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
  logic [3:0]  a4, b4, sum4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation with out_ready=1; return observed result, the cycle
  // (counted from the accept cycle = 0) where out_valid was first seen, and
  // a timeout flag. Returns in the cycle after the output handshake.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                       output logic [15:0] s, output logic c, output int lat, output bit to);
    int guard;
    guard = 0;
    to  = 1'b0;
    lat = 0;
    s   = '0;
    c   = 1'b0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      to = 1'b1;
      return;
    end
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      to = 1'b1;
      return;
    end
    s = sum;
    c = cout;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
    tick();
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
    n_checks++; if (out_valid4 !== 1'b0 || sum4 !== 4'h0) begin n_fail++; $display("FAIL reset_w4: got ov=%b sum=%h expected 0/0", out_valid4, sum4); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [15:0] va[3];
    logic [15:0] vb[3];
    logic        vc[3];
    logic [15:0] es[3];
    logic        ec[3];
    logic [15:0] s;
    logic        c;
    int          lat;
    bit          to;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; es[0] = 16'h0000; ec[0] = 1'b1;
    va[1] = 16'h1234; vb[1] = 16'h4321; vc[1] = 1'b1; es[1] = 16'h5556; ec[1] = 1'b0;
    va[2] = 16'h0FFF; vb[2] = 16'h0001; vc[2] = 1'b0; es[2] = 16'h1000; ec[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], vc[i], s, c, lat, to);
      n_checks++;
      if (to) begin
        n_fail++; $display("FAIL directed_timeout[%0d]: got timeout expected result", i);
      end else begin
        n_checks++; if (s !== es[i]) begin n_fail++; $display("FAIL directed_sum[%0d]: got %h expected %h", i, s, es[i]); end
        n_checks++; if (c !== ec[i]) begin n_fail++; $display("FAIL directed_cout[%0d]: got %b expected %b", i, c, ec[i]); end
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 5", i, lat); end
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL directed_return_idle[%0d]: got ir=%b ov=%b expected 1/0", i, in_ready, out_valid); end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ta, tb_, s;
    logic        tc, c;
    logic [16:0] expv;
    int          lat;
    bit          to;
    for (int i = 0; i < 25; i++) begin
      ta = 16'($urandom); tb_ = 16'($urandom); tc = 1'($urandom);
      if (i == 0) begin ta = 16'hFFFF; tb_ = 16'hFFFF; tc = 1'b1; end
      expv = {1'b0, ta} + {1'b0, tb_} + {16'h0, tc};
      do_op(ta, tb_, tc, s, c, lat, to);
      n_checks++;
      if (to) begin
        n_fail++; $display("FAIL random_timeout[%0d]: got timeout expected result", i);
      end else if ({c, s} !== expv || lat != 5) begin
        n_fail++;
        $display("FAIL random[%0d] %h+%h+%b: got cout=%b sum=%h lat=%0d expected cout=%b sum=%h lat=5",
                 i, ta, tb_, tc, c, s, lat, expv[16], expv[15:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ta, tb_;
    logic        tc;
    logic [16:0] expv;
    int          guard;
    ta = 16'($urandom); tb_ = 16'($urandom); tc = 1'b1;
    expv = {1'b0, ta} + {1'b0, tb_} + {16'h0, tc};
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      tick();
      guard++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++; $display("FAIL bp_timeout: got no out_valid expected out_valid");
      return;
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== expv) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b cout=%b sum=%h expected 1/0/%b/%h",
                 k, out_valid, in_ready, cout, sum, expv[16], expv[15:0]);
      end
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = 1'($urandom);
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b1 || {cout, sum} !== expv) begin
      n_fail++; $display("FAIL bp_final_hold: got ov=%b cout=%b sum=%h expected 1/%b/%h", out_valid, cout, sum, expv[16], expv[15:0]);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] s;
    logic        c;
    int          lat;
    bit          to;
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_run_reset: got ov=%b sum=%h cout=%b ir=%b expected 0/0000/0/0", out_valid, sum, cout, in_ready);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_run_idle: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
    end
    do_op(16'h0002, 16'h0003, 1'b0, s, c, lat, to);
    n_checks++;
    if (to || s !== 16'h0005 || c !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_op: got to=%b sum=%h cout=%b expected 0/0005/0", to, s, c);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa[3];
    logic [15:0] pb[3];
    logic        pc[3];
    logic [16:0] expq[$];
    logic [16:0] e;
    int          acc[3];
    int          got, nxt;
    bit          extra;
    for (int i = 0; i < 3; i++) begin
      pa[i] = 16'($urandom); pb[i] = 16'($urandom); pc[i] = 1'($urandom); acc[i] = 0;
    end
    got = 0; nxt = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    a = pa[0]; b = pb[0]; cin = pc[0];
    for (int cyc = 0; cyc < 80 && got < 3; cyc++) begin
      if (out_valid) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected: got result %h expected none", sum);
        end else begin
          e = expq.pop_front();
          if ({cout, sum} !== e) begin
            n_fail++; $display("FAIL b2b_result[%0d]: got cout=%b sum=%h expected %b/%h", got, cout, sum, e[16], e[15:0]);
          end
        end
        got++;
      end
      if (nxt == 3 && !in_ready) in_valid = 1'b0;
      if (in_ready && nxt < 3) begin
        a = pa[nxt]; b = pb[nxt]; cin = pc[nxt];
        expq.push_back({1'b0, pa[nxt]} + {1'b0, pb[nxt]} + {16'h0, pc[nxt]});
        acc[nxt] = cyc;
        nxt++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (got != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", got); end
    n_checks++; if (acc[1] - acc[0] != 6) begin n_fail++; $display("FAIL b2b_period01: got %0d expected 6", acc[1] - acc[0]); end
    n_checks++; if (acc[2] - acc[1] != 6) begin n_fail++; $display("FAIL b2b_period12: got %0d expected 6", acc[2] - acc[1]); end
    extra = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) extra = 1'b1;
      tick();
    end
    n_checks++; if (extra) begin n_fail++; $display("FAIL b2b_extra_accept: got spurious out_valid expected none"); end
  endtask

  task automatic test_width4();
    logic [3:0] ta, tb_;
    logic       tc;
    logic [4:0] expv;
    int         lat;
    for (int i = 0; i < 8; i++) begin
      ta = 4'($urandom); tb_ = 4'($urandom); tc = 1'($urandom);
      if (i == 0) begin ta = 4'hF; tb_ = 4'hF; tc = 1'b1; end
      expv = {1'b0, ta} + {1'b0, tb_} + {4'h0, tc};
      a4 = ta; b4 = tb_; cin4 = tc; in_valid4 = 1'b1; out_ready4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      lat = 1;
      while (!out_valid4 && lat < 20) begin
        tick();
        lat++;
      end
      n_checks++;
      if (!out_valid4 || lat != 2 || {cout4, sum4} !== expv) begin
        n_fail++;
        $display("FAIL w4[%0d] %h+%h+%b: got ov=%b lat=%0d cout=%b sum=%h expected 1/2/%b/%h",
                 i, ta, tb_, tc, out_valid4, lat, cout4, sum4, expv[4], expv[3:0]);
      end
      tick();
      n_checks++;
      if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL w4_idle[%0d]: got ir=%b expected 1", i, in_ready4); end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_width4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
